// File: rtl/conv_win_pkg.sv
// Shared types and helpers for the K x K sliding-window generator.
// Holds the default pixel type, legal K/STRIDE ranges and the
// flat window index mapping used to pack out_win.
package conv_win_pkg;

  localparam int PIX_DW     = 16;
  localparam int K_MIN      = 2;
  localparam int K_MAX      = 7;
  localparam int STRIDE_MIN = 1;

  typedef logic signed [PIX_DW-1:0] pixel_t;

  // Flat element index of (channel c, row r, column k) in a kk x kk window.
  function automatic int idx(input int c, input int r, input int k, input int kk);
    return (c * kk + r) * kk + k;
  endfunction

endpackage

// File: rtl/conv_line_ram.sv
// One line buffer: MAX_W x DW, single write port, asynchronous read.
// A write and a read on the same address in the same cycle return the
// old contents, which is what lets the line buffers form a cascade.
module conv_line_ram #(
  parameter int DW    = 16,
  parameter int MAX_W = 64,
  parameter int AW    = $clog2(MAX_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [MAX_W];

  // Store the incoming sample at the current column.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K x K x CH sliding-window generator with valid/ready on both
// sides, runtime line length / frame height, output stride and frame
// markers. K-1 line buffers per channel hold the previous lines.
// Optional statistics outputs (win_cnt, stall_cnt) are built only when
// CONV_WIN_STATS_EN is defined.
module conv_window_gen
  import conv_win_pkg::*;
#(
  parameter int DW     = 16,
  parameter int K      = 3,
  parameter int CH     = 1,
  parameter int MAX_W  = 64,
  parameter int STRIDE = 1,
  parameter int AW     = $clog2(MAX_W)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [AW:0]            line_len,
  input  logic [15:0]            img_h,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [CH*DW-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH*K*K*DW-1:0]   out_win,
  output logic                   out_eof
`ifdef CONV_WIN_STATS_EN
  ,
  output logic [31:0]            win_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  // Frame position of the next pixel and latched frame geometry
  logic [AW-1:0] r_col;
  logic [15:0]   r_row;
  logic [PW-1:0] r_cp;
  logic [PW-1:0] r_rp;
  logic [AW:0]   r_len;
  logic [15:0]   r_h;
  logic          r_armed;

  // Window shift register, one K x K tile per channel
  logic [DW-1:0] r_win [CH][K][K];

  logic          w_accept;
  logic          w_active;
  logic [AW:0]   w_len_clamped;
  logic [AW:0]   w_len;
  logic [15:0]   w_h;
  logic [AW-1:0] w_col;
  logic [15:0]   w_row;
  logic [PW-1:0] w_cp;
  logic [PW-1:0] w_rp;
  logic [PW-1:0] w_cp_inc;
  logic [PW-1:0] w_rp_inc;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_emit;
  logic          w_eof;
  logic [AW+1:0] w_col_reach;
  logic [16:0]   w_row_reach;

  logic [DW-1:0]         w_rd      [CH][K-1];
  logic [DW-1:0]         w_wd      [CH][K-1];
  logic [DW-1:0]         w_vsmp    [CH][K];
  logic [DW-1:0]         w_win_next[CH][K][K];
  logic [CH*K*K*DW-1:0]  w_win_flat;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  // Pixels that arrive outside an armed frame are taken but ignored.
  assign w_active = w_accept && (in_sof || r_armed);

  // Bring an out-of-range line length back to the nearest legal bound.
  always_comb begin
    w_len_clamped = line_len;
    if (line_len > (AW+1)'(MAX_W)) w_len_clamped = (AW+1)'(MAX_W);
    else if (line_len < (AW+1)'(K)) w_len_clamped = (AW+1)'(K);
  end

  // A start-of-frame pixel sits at (0,0) with fresh geometry.
  assign w_len = in_sof ? w_len_clamped : r_len;
  assign w_h   = in_sof ? img_h         : r_h;
  assign w_col = in_sof ? '0 : r_col;
  assign w_row = in_sof ? '0 : r_row;
  assign w_cp  = in_sof ? '0 : r_cp;
  assign w_rp  = in_sof ? '0 : r_rp;

  assign w_cp_inc = (w_cp == PW'(STRIDE - 1)) ? '0 : w_cp + PW'(1);
  assign w_rp_inc = (w_rp == PW'(STRIDE - 1)) ? '0 : w_rp + PW'(1);

  assign w_col_last = ({1'b0, w_col} == w_len - (AW+1)'(1));
  assign w_row_last = (w_row == w_h - 16'd1);

  assign w_emit = w_active && (w_row >= 16'(K - 1)) && ({1'b0, w_col} >= (AW+1)'(K - 1))
                  && (w_cp == '0) && (w_rp == '0);

  // The window is the last of the frame when the next stride step would
  // fall outside the line and outside the frame.
  assign w_col_reach = {2'b00, w_col} + (AW+2)'(STRIDE);
  assign w_row_reach = {1'b0, w_row} + 17'(STRIDE);
  assign w_eof       = (w_col_reach >= {1'b0, w_len}) && (w_row_reach >= {1'b0, w_h});

  genvar gi, gj, gk;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      // Line buffer cascade: buffer 0 takes the new pixel, buffer j takes
      // what buffer j-1 held at this column.
      for (gj = 0; gj < K - 1; gj++) begin : g_ram
        if (gj == 0) begin : g_first
          assign w_wd[gi][gj] = in_data[gi*DW +: DW];
        end else begin : g_casc
          assign w_wd[gi][gj] = w_rd[gi][gj-1];
        end
        conv_line_ram #(
          .DW    (DW),
          .MAX_W (MAX_W),
          .AW    (AW)
        ) u_line_ram (
          .clk   (clk),
          .we    (w_active),
          .addr  (w_col),
          .wdata (w_wd[gi][gj]),
          .rdata (w_rd[gi][gj])
        );
      end
      // Vertical column: row 0 is the oldest line (deepest buffer).
      for (gj = 0; gj < K; gj++) begin : g_row
        if (gj == K - 1) begin : g_new
          assign w_vsmp[gi][gj] = in_data[gi*DW +: DW];
        end else begin : g_old
          assign w_vsmp[gi][gj] = w_rd[gi][K-2-gj];
        end
        for (gk = 0; gk < K; gk++) begin : g_col
          if (gk == K - 1) begin : g_in
            assign w_win_next[gi][gj][gk] = w_vsmp[gi][gj];
          end else begin : g_shift
            assign w_win_next[gi][gj][gk] = r_win[gi][gj][gk+1];
          end
          assign w_win_flat[idx(gi, gj, gk, K)*DW +: DW] = w_win_next[gi][gj][gk];
        end
      end
    end
  endgenerate

  // Advance row/column/phase counters and frame arming per active pixel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_col   <= '0;
      r_row   <= '0;
      r_cp    <= '0;
      r_rp    <= '0;
      r_len   <= (AW+1)'(K);
      r_h     <= 16'(K);
      r_armed <= 1'b0;
    end else if (w_active) begin
      r_len   <= w_len;
      r_h     <= w_h;
      r_armed <= 1'b1;
      if (w_col_last) begin
        r_col <= '0;
        r_cp  <= '0;
        if (w_row_last) begin
          r_row   <= '0;
          r_rp    <= '0;
          r_armed <= 1'b0;
        end else begin
          r_row <= w_row + 16'd1;
          r_rp  <= (w_row >= 16'(K - 1)) ? w_rp_inc : '0;
        end
      end else begin
        r_col <= w_col + AW'(1);
        r_cp  <= ({1'b0, w_col} >= (AW+1)'(K - 1)) ? w_cp_inc : '0;
        r_row <= w_row;
        r_rp  <= w_rp;
      end
    end
  end

  // Shift the new vertical column into the window.
  always_ff @(posedge clk) begin
    if (w_active) r_win <= w_win_next;
  end

  // Output register: load on emit, drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_win   <= '0;
    end else if (w_emit) begin
      out_valid <= 1'b1;
      out_eof   <= w_eof;
      out_win   <= w_win_flat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

`ifdef CONV_WIN_STATS_EN
  // Saturating hand-off and stall counters, cleared by an accepted sof.
  always_ff @(posedge clk) begin
    if (!resetn || (w_accept && in_sof)) begin
      win_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready && (win_cnt != '1)) win_cnt <= win_cnt + 32'd1;
      if (in_valid && !in_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
